// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//   Fetch sequencer for a 32-bit instruction memory. Owns the byte PC, drives
//   the memory word address, captures {pc, instruction} pairs into a small
//   prefetch FIFO and hands them to decode over a valid/ready handshake.
//   Redirects flush the FIFO and restart fetch; halt stops new fetches while
//   the FIFO keeps draining.
//
//   Optional feature macro: IFETCH_PERF_CNT_EN
//     When defined, adds perf_fetch_cnt and perf_redirect_cnt outputs.
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_inst,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            halted
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [XLEN-1:0] pc_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [XLEN-1:0] inst_q_r [FIFO_DEPTH];
    logic [XLEN-1:0] pc_q_r   [FIFO_DEPTH];
    logic            deq_s;
    logic            enq_s;

    // Head of the FIFO and status are presented straight from registers.
    assign if_valid  = (count_r != {CW{1'b0}});
    assign if_inst   = inst_q_r[rd_ptr_r];
    assign if_pc     = pc_q_r[rd_ptr_r];
    assign halted    = (state_r == ST_HALT);
    assign imem_addr = {2'b00, pc_r[XLEN-1:2]};

    // Next-state logic; BOOT always leaves after one cycle, RUN/HALT follow halt.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_BOOT: state_s = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!halt) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: state_s = ST_BOOT;
        endcase
    end

    // Handshake strobes: a pop whenever decode takes the head, a fetch only in
    // RUN with no halt/redirect and room (or a slot being freed this cycle).
    always_comb begin
        deq_s = 1'b0;
        enq_s = 1'b0;
        deq_s = if_valid & if_ready;
        if ((state_r == ST_RUN) && !halt && !redirect_valid &&
            ((count_r < DEPTH_C) || deq_s)) begin
            enq_s = 1'b1;
        end else begin
            enq_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // PC: redirect wins, otherwise advance by one word on each fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= redirect_pc & ALIGN_MASK;
        end else if (enq_s) begin
            pc_r <= pc_r + PC_STEP;
        end
    end

    // FIFO pointers and occupancy; a redirect discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else if (redirect_valid) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: capture the returned word together with its byte PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                inst_q_r[i] <= {XLEN{1'b0}};
                pc_q_r[i]   <= {XLEN{1'b0}};
            end
        end else if (enq_s) begin
            inst_q_r[wr_ptr_r] <= imem_inst;
            pc_q_r[wr_ptr_r]   <= pc_r;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Performance counters: fetches issued and redirect cycles seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt    <= 32'd0;
            perf_redirect_cnt <= 32'd0;
        end else begin
            if (enq_s) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//   Directed bench for inst_fetch_ctrl. Memory word w returns (w+1)*0x11, so
//   words 0..3 read 0x11, 0x22, 0x33, 0x44. Inputs change and outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int tests_run;
    int tests_failed;

    inst_fetch_ctrl #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    // Combinational instruction memory model.
    assign imem_inst = (imem_addr + 32'd1) * 32'h0000_0011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the following falling edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_inst",  if_inst,  32'd0);
        check("rst_pc",    if_pc,    32'd0);
        check("rst_halted",{31'd0, halted}, 32'd0);
        check("rst_addr",  imem_addr, 32'd0);

        // 1: latency and streaming throughput
        tick(1);
        check("boot_valid", {31'd0, if_valid}, 32'd0);
        tick(1);
        check("s1_valid", {31'd0, if_valid}, 32'd1);
        check("s1_pc0",   if_pc,   32'h0);
        check("s1_inst0", if_inst, 32'h11);
        tick(1);
        check("s1_pc4",   if_pc,   32'h4);
        check("s1_inst4", if_inst, 32'h22);
        tick(1);
        check("s1_pc8",   if_pc,   32'h8);
        check("s1_inst8", if_inst, 32'h33);
        tick(1);
        check("s1_pcC",   if_pc,   32'hC);
        check("s1_instC", if_inst, 32'h44);

        // 2: back-pressure fills FIFO and freezes pc
        do_reset();
        if_ready = 1'b0;
        tick(5);
        check("s2_valid", {31'd0, if_valid}, 32'd1);
        check("s2_addr",  imem_addr, 32'd2);
        check("s2_head0", if_pc, 32'h0);
        if_ready = 1'b1;
        tick(1);
        check("s2_head4", if_pc, 32'h4);
        check("s2_inst4", if_inst, 32'h22);
        tick(1);
        check("s2_head8", if_pc, 32'h8);
        check("s2_inst8", if_inst, 32'h33);

        // 3: redirect with full FIFO (contents 8, C)
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick(1);
        redirect_valid = 1'b0;
        check("s3_flush", {31'd0, if_valid}, 32'd0);
        check("s3_addr",  imem_addr, 32'h40);
        tick(1);
        check("s3_valid", {31'd0, if_valid}, 32'd1);
        check("s3_pc",    if_pc,   32'h100);
        check("s3_inst",  if_inst, 32'h451);

        // 4: halt with one entry queued
        halt     = 1'b1;
        if_ready = 1'b1;
        tick(1);
        check("s4_halted", {31'd0, halted}, 32'd1);
        check("s4_drain",  {31'd0, if_valid}, 32'd0);
        check("s4_addr",   imem_addr, 32'h41);
        tick(2);
        check("s4_frozen", imem_addr, 32'h41);
        halt = 1'b0;
        tick(1);
        check("s4_resume", {31'd0, halted}, 32'd0);
        check("s4_empty",  {31'd0, if_valid}, 32'd0);
        tick(1);
        check("s4_pc",   if_pc,   32'h104);
        check("s4_inst", if_inst, 32'h462);

        // 5: redirect near the top of the address space, PC wraps
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick(1);
        redirect_valid = 1'b0;
        check("s5_flush", {31'd0, if_valid}, 32'd0);
        tick(1);
        check("s5_pcTop",   if_pc,   32'hFFFF_FFFC);
        check("s5_instTop", if_inst, 32'h4000_0000);
        tick(1);
        check("s5_pc0",   if_pc,   32'h0);
        check("s5_inst0", if_inst, 32'h11);
        tick(1);
        check("s5_pc4",   if_pc,   32'h4);

`ifdef IFETCH_PERF_CNT_EN
        // 6: counters after ten fetches and one redirect
        do_reset();
        check("s6_rst_fetch", perf_fetch_cnt,    32'd0);
        check("s6_rst_redir", perf_redirect_cnt, 32'd0);
        tick(11);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick(1);
        redirect_valid = 1'b0;
        check("s6_fetch", perf_fetch_cnt,    32'd10);
        check("s6_redir", perf_redirect_cnt, 32'd1);
        do_reset();
        check("s6_clr_fetch", perf_fetch_cnt,    32'd0);
        check("s6_clr_redir", perf_redirect_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
